// File: rtl/laser_mode_sequencer.sv
// Two-colour laser mode sequencer: short press cycles OFF->A->B->ALT, long press forces OFF.
// Optional build macro FRAME_SYNC_EN: ALT-mode laser phases end on a frame_sync pulse instead of a count.
module laser_mode_sequencer #(
  parameter int LONG_CYCLES = 50000000,
  parameter int ALT_CYCLES  = 500000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_state,
  input  logic       pb_down,
  input  logic       pb_up,
`ifdef FRAME_SYNC_EN
  input  logic       frame_sync,
`endif
  output logic [1:0] mode,
  output logic       laser_a_en,
  output logic       laser_b_en,
  output logic       long_press
);

  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam int PH_MAX = (ALT_CYCLES > DEAD_CYCLES) ? ALT_CYCLES : DEAD_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [PH_W-1:0]   ALT_LAST  = PH_W'(ALT_CYCLES - 1);
  localparam logic [PH_W-1:0]   DEAD_LAST = PH_W'(DEAD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESSED   = 2'd1;
  localparam logic [1:0] ST_LONG_HELD = 2'd2;

  localparam logic [1:0] PH_A    = 2'd0;
  localparam logic [1:0] DEAD_AB = 2'd1;
  localparam logic [1:0] PH_B    = 2'd2;
  localparam logic [1:0] DEAD_BA = 2'd3;

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_A   = 2'd1;
  localparam logic [1:0] MODE_B   = 2'd2;
  localparam logic [1:0] MODE_ALT = 2'd3;

  logic [1:0]        press_st;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        phase;
  logic [PH_W-1:0]   ph_cnt;
  logic              ph_done;

  // Press classification: release before the terminal count is a short press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_st   <= ST_IDLE;
      hold_cnt   <= '0;
      mode       <= MODE_OFF;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      case (press_st)
        ST_IDLE: begin
          if (pb_down) begin
            press_st <= ST_PRESSED;
            hold_cnt <= '0;
          end
        end
        ST_PRESSED: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          if (pb_up) begin
            mode     <= mode + 2'd1;
            press_st <= ST_IDLE;
          end else if (!pb_state) begin
            press_st <= ST_IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            mode       <= MODE_OFF;
            long_press <= 1'b1;
            press_st   <= ST_LONG_HELD;
          end
        end
        ST_LONG_HELD: begin
          if (pb_up || !pb_state) press_st <= ST_IDLE;
        end
        default: press_st <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ph_done = 1'b0;
    case (phase)
`ifdef FRAME_SYNC_EN
      PH_A, PH_B: ph_done = frame_sync;
`else
      PH_A, PH_B: ph_done = (ph_cnt == ALT_LAST);
`endif
      DEAD_AB, DEAD_BA: ph_done = (ph_cnt == DEAD_LAST);
      default: ph_done = 1'b1;
    endcase
  end

  // Phase sequencer idles at PH_A so every ALT entry begins with laser A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= PH_A;
      ph_cnt <= '0;
    end else if (mode != MODE_ALT) begin
      phase  <= PH_A;
      ph_cnt <= '0;
    end else if (ph_done) begin
      phase  <= phase + 2'd1;
      ph_cnt <= '0;
    end else begin
      ph_cnt <= ph_cnt + PH_W'(1);
    end
  end

  // Both enables decode from one registered mode/phase pair, so they can never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      laser_a_en <= 1'b0;
      laser_b_en <= 1'b0;
    end else begin
      case (mode)
        MODE_A: begin
          laser_a_en <= 1'b1;
          laser_b_en <= 1'b0;
        end
        MODE_B: begin
          laser_a_en <= 1'b0;
          laser_b_en <= 1'b1;
        end
        MODE_ALT: begin
          laser_a_en <= (phase == PH_A);
          laser_b_en <= (phase == PH_B);
        end
        default: begin
          laser_a_en <= 1'b0;
          laser_b_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_mode_sequencer.sv
// Scoreboard bench for laser_mode_sequencer: a timestamp-based reference model queues the
// expected outputs after every clock edge and a monitor compares them half a cycle later.
module tb_laser_mode_sequencer;

  localparam int LONG   = 16;
  localparam int ALT    = 8;
  localparam int DEAD   = 2;
  localparam int PERIOD = 2 * ALT + 2 * DEAD;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic pb_state = 1'b0;
  logic pb_down  = 1'b0;
  logic pb_up    = 1'b0;
`ifdef FRAME_SYNC_EN
  logic frame_sync = 1'b0;
`endif
  logic [1:0] mode;
  logic       laser_a_en;
  logic       laser_b_en;
  logic       long_press;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_q[$];

  int m_mode    = 0;
  int press_st  = 0;   // 0 idle, 1 waiting for release or timeout, 2 long already reported
  int down_edge = 0;
  int edge_no   = 0;
  int alt_age   = 0;

  laser_mode_sequencer #(
    .LONG_CYCLES(LONG),
    .ALT_CYCLES (ALT),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb_state  (pb_state),
    .pb_down   (pb_down),
    .pb_up     (pb_up),
`ifdef FRAME_SYNC_EN
    .frame_sync(frame_sync),
`endif
    .mode      (mode),
    .laser_a_en(laser_a_en),
    .laser_b_en(laser_b_en),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, required %b ({mode,a,b,long})", name, $time, act, req);
    end
  endtask

  // Reference model: lasers come from where we are in the ALT period, presses from edge timestamps.
  always @(posedge clk or negedge rst_n) begin : model
    int pos;
    logic a, b, lp;
    if (!rst_n) begin
      m_mode   = 0;
      press_st = 0;
      alt_age  = 0;
      exp_q.delete();
    end else begin
      if (m_mode == 3) begin
        pos = alt_age % PERIOD;
        a = (pos < ALT);
        b = (pos >= ALT + DEAD) && (pos < 2 * ALT + DEAD);
        alt_age++;
      end else begin
        alt_age = 0;
        a = (m_mode == 1);
        b = (m_mode == 2);
      end
      lp = 1'b0;
      case (press_st)
        0: if (pb_down) begin press_st = 1; down_edge = edge_no; end
        1: begin
          if (pb_up) begin
            m_mode = (m_mode + 1) % 4;
            press_st = 0;
          end else if (!pb_state) begin
            press_st = 0;
          end else if (edge_no - down_edge == LONG) begin
            m_mode = 0;
            lp = 1'b1;
            press_st = 2;
          end
        end
        default: if (pb_up || !pb_state) press_st = 0;
      endcase
      edge_no++;
      exp_q.push_back({m_mode[1:0], a, b, lp});
    end
  end

  always @(negedge clk) begin : monitor
    logic [4:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", {mode, laser_a_en, laser_b_en, long_press}, e);
      check("a_and_b_exclusive", {4'b0, laser_a_en & laser_b_en}, 5'b0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold);
    pb_down = 1'b1; pb_state = 1'b1;
    @(negedge clk);
    pb_down = 1'b0;
    repeat (hold - 1) @(negedge clk);
    pb_up = 1'b1; pb_state = 1'b0;
    @(negedge clk);
    pb_up = 1'b0;
  endtask

  initial begin
    idle(3);
    check("reset_state", {mode, laser_a_en, laser_b_en, long_press}, 5'b0);
    #2 rst_n = 1'b1;
    idle(2);

    // Four short presses walk through every mode and back to OFF
    for (int i = 0; i < 4; i++) begin
      press(5);
      idle(25);
    end

    // Mode B then a long hold forces OFF
    press(5); idle(3);
    press(5); idle(5);
    press(20); idle(5);

    // Release coincident with the terminal count counts as short
    press(5); idle(3);
    press(16); idle(3);

    // ALT run
    press(5); idle(45);

    for (int i = 0; i < 30; i++) begin
      press(int'($urandom_range(1, 24)));
      idle(int'($urandom_range(0, 30)));
    end

    // Reach ALT with known phase, then reset while holding the button in PH_B
    press(3); idle(2);
    for (int i = 0; i < 4 && m_mode != 3; i++) begin
      press(3); idle(2);
    end
    pb_down = 1'b1; pb_state = 1'b1;
    @(negedge clk);
    pb_down = 1'b0;
    idle(8);
    @(posedge clk);
    #1 check("in_ph_b", {4'b0, laser_b_en}, 5'b1);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {mode, laser_a_en, laser_b_en, long_press}, 5'b0);
    idle(2);
    check("reset_held", {mode, laser_a_en, laser_b_en, long_press}, 5'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    pb_up = 1'b1; pb_state = 1'b0;
    @(negedge clk);
    pb_up = 1'b0;
    idle(5);
    check("stale_release_ignored", {mode, laser_a_en, laser_b_en, long_press}, 5'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
